agendador_rega: RTL and testbench

AGENDADOR_REGA -- requirements
Module: agendador_rega

---
 rtl/agendador_rega_pkg.sv | 31 +++
 rtl/agendador_rega_divisor_dia.sv | 37 +++
 rtl/agendador_rega.sv | 158 +++++++++++++++
 tb/tb_agendador_rega.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/agendador_rega_pkg.sv
// Shared definitions for the three-plant watering scheduler: FSM encoding,
// field widths, default timing and the pending-plant selector.
package agendador_rega_pkg;

    localparam int PLANTA_W          = 2;
    localparam int PERIODO_W         = 4;
    localparam int NPLANTAS          = 3;
    localparam int TICKS_POR_DIA_DEF = 5184000;
    localparam int TEMPO_REGA_DEF    = 600;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REGA  = 2'd1,
        PAUSA = 2'd2
    } estado_t;

    // Lowest-index set bit; returns 0 when nothing is pending.
    function automatic logic [PLANTA_W-1:0] menor_pendente(input logic [NPLANTAS-1:0] pend);
        logic [PLANTA_W-1:0] idx;
        idx = '0;
        for (int i = NPLANTAS - 1; i >= 0; i--) begin
            if (pend[i]) begin
                idx = PLANTA_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/agendador_rega_divisor_dia.sv
// Free-running day prescaler: counts 0..TICKS_POR_DIA-1 and flags the last tick.
module divisor_dia
    import agendador_rega_pkg::*;
#(
    parameter int TICKS_POR_DIA = TICKS_POR_DIA_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic day_tick
);

    localparam int CW = (TICKS_POR_DIA > 1) ? $clog2(TICKS_POR_DIA) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign day_tick = (cnt_q == CW'(TICKS_POR_DIA - 1));

    // Next count with wrap at the end of the day.
    always_comb begin
        if (day_tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/agendador_rega.sv
// Watering scheduler: per-plant day counters raise pending requests that a
// small FSM serves one at a time, lowest plant index first.
module agendador_rega
    import agendador_rega_pkg::*;
#(
    parameter int TICKS_POR_DIA = TICKS_POR_DIA_DEF,
    parameter int TEMPO_REGA    = TEMPO_REGA_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_valid,
    input  logic [PLANTA_W-1:0]  cfg_planta,
    input  logic [PERIODO_W-1:0] cfg_periodo,
    output logic                 pump1,
    output logic                 pump2,
    output logic                 pump3,
    output logic                 regando,
    output logic [PLANTA_W-1:0]  planta_ativa
);

    localparam int DW = (TEMPO_REGA > 1) ? $clog2(TEMPO_REGA) : 1;

    logic day_tick_s;

    divisor_dia #(.TICKS_POR_DIA(TICKS_POR_DIA)) u_divisor_dia (
        .clk      (clk),
        .rst      (rst),
        .day_tick (day_tick_s)
    );

    logic [NPLANTAS-1:0][PERIODO_W-1:0] periodo_q, periodo_d;
    logic [NPLANTAS-1:0][PERIODO_W-1:0] dias_q, dias_d;
    logic [NPLANTAS-1:0]                pend_q, pend_d;
    estado_t                            estado_q, estado_d;
    logic [PLANTA_W-1:0]                ativa_q, ativa_d;
    logic [DW-1:0]                      dur_q, dur_d;
    logic [NPLANTAS-1:0]                pump_q, pump_d;
    logic                               regando_q, regando_d;
    logic [PLANTA_W-1:0]                planta_ativa_q, planta_ativa_d;

    logic [NPLANTAS-1:0] cfg_hit_s;
    logic [NPLANTAS-1:0] elegivel_s;
    logic [PLANTA_W-1:0] sel_s;
    logic                inicio_s;

    // Next-state logic for the plant counters, the FSM and the output registers.
    always_comb begin
        for (int i = 0; i < NPLANTAS; i++) begin
            cfg_hit_s[i] = cfg_valid && (cfg_planta == PLANTA_W'(i));
        end
        // A plant being reconfigured this cycle must not start watering.
        elegivel_s = pend_q & ~cfg_hit_s;
        sel_s      = menor_pendente(elegivel_s);

        estado_d = estado_q;
        ativa_d  = ativa_q;
        dur_d    = dur_q;
        inicio_s = 1'b0;
        case (estado_q)
            IDLE: begin
                if (|elegivel_s) begin
                    estado_d = REGA;
                    ativa_d  = sel_s;
                    dur_d    = '0;
                    inicio_s = 1'b1;
                end else begin
                    estado_d = IDLE;
                end
            end
            REGA: begin
                if (cfg_valid && (cfg_planta == ativa_q)) begin
                    estado_d = PAUSA;
                    dur_d    = '0;
                end else if (dur_q == DW'(TEMPO_REGA - 1)) begin
                    estado_d = PAUSA;
                    dur_d    = '0;
                end else begin
                    dur_d = dur_q + DW'(1);
                end
            end
            PAUSA: begin
                estado_d = IDLE;
            end
            default: begin
                estado_d = IDLE;
                dur_d    = '0;
            end
        endcase

        for (int i = 0; i < NPLANTAS; i++) begin
            periodo_d[i] = periodo_q[i];
            dias_d[i]    = dias_q[i];
            pend_d[i]    = pend_q[i];
            if (inicio_s && (sel_s == PLANTA_W'(i))) begin
                pend_d[i] = 1'b0;
            end else begin
                pend_d[i] = pend_q[i];
            end
            // Configuration wins; otherwise a day tick may re-arm pend even as it is served.
            if (cfg_hit_s[i]) begin
                periodo_d[i] = cfg_periodo;
                dias_d[i]    = '0;
                pend_d[i]    = 1'b0;
            end else if (day_tick_s && (periodo_q[i] != '0)) begin
                if ((dias_q[i] + PERIODO_W'(1)) == periodo_q[i]) begin
                    dias_d[i] = '0;
                    pend_d[i] = 1'b1;
                end else begin
                    dias_d[i] = dias_q[i] + PERIODO_W'(1);
                end
            end else begin
                dias_d[i] = dias_q[i];
            end
        end

        regando_d = (estado_d == REGA);
        for (int i = 0; i < NPLANTAS; i++) begin
            pump_d[i] = regando_d && (ativa_d == PLANTA_W'(i));
        end
        if (regando_d) begin
            planta_ativa_d = ativa_d;
        end else begin
            planta_ativa_d = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            periodo_q      <= '0;
            dias_q         <= '0;
            pend_q         <= '0;
            estado_q       <= IDLE;
            ativa_q        <= '0;
            dur_q          <= '0;
            pump_q         <= '0;
            regando_q      <= 1'b0;
            planta_ativa_q <= '0;
        end else begin
            periodo_q      <= periodo_d;
            dias_q         <= dias_d;
            pend_q         <= pend_d;
            estado_q       <= estado_d;
            ativa_q        <= ativa_d;
            dur_q          <= dur_d;
            pump_q         <= pump_d;
            regando_q      <= regando_d;
            planta_ativa_q <= planta_ativa_d;
        end
    end

    assign pump1        = pump_q[0];
    assign pump2        = pump_q[1];
    assign pump3        = pump_q[2];
    assign regando      = regando_q;
    assign planta_ativa = planta_ativa_q;

endmodule

// File: tb/tb_agendador_rega.sv
// Randomised bench for agendador_rega with a behavioural model of the
// watering schedule (day counts, pending flags, remaining watering time).
module tb_agendador_rega;

    localparam int T  = 10;
    localparam int TR = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_valid = 1'b0;
    logic [1:0] cfg_planta = 2'd0;
    logic [3:0] cfg_periodo = 4'd0;
    logic       pump1, pump2, pump3, regando;
    logic [1:0] planta_ativa;

    int n_cmp = 0;
    int n_err = 0;

    // model state
    int m_presc;
    int m_per[3];
    int m_dias[3];
    bit m_pend[3];
    bit m_regando;
    bit m_pausa;
    int m_rest;
    int m_ativa;

    agendador_rega #(.TICKS_POR_DIA(T), .TEMPO_REGA(TR)) dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_valid    (cfg_valid),
        .cfg_planta   (cfg_planta),
        .cfg_periodo  (cfg_periodo),
        .pump1        (pump1),
        .pump2        (pump2),
        .pump3        (pump3),
        .regando      (regando),
        .planta_ativa (planta_ativa)
    );

    always #5 clk = ~clk;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        n_cmp++;
        if (obs !== esp) begin
            n_err++;
            $display("FAIL %s: observed %h expected %h at %0t", tag, obs, esp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_presc   = 0;
        m_regando = 0;
        m_pausa   = 0;
        m_rest    = 0;
        m_ativa   = 0;
        for (int i = 0; i < 3; i++) begin
            m_per[i]  = 0;
            m_dias[i] = 0;
            m_pend[i] = 0;
        end
    endtask

    // One rising edge of the scheduler described in terms of days and requests.
    task automatic modelo_passo(input bit v, input int p, input int per);
        bit tick;
        bit hit[3];
        int sel;
        tick = (m_presc == T - 1);
        m_presc = tick ? 0 : m_presc + 1;
        sel = -1;
        for (int i = 0; i < 3; i++) hit[i] = v && (p == i);
        if (m_pausa) begin
            m_pausa = 0;
        end else if (m_regando) begin
            m_rest--;
            if (hit[m_ativa] || m_rest == 0) begin
                m_regando = 0;
                m_pausa   = 1;
            end
        end else begin
            for (int i = 2; i >= 0; i--) if (m_pend[i] && !hit[i]) sel = i;
            if (sel >= 0) begin
                m_regando   = 1;
                m_ativa     = sel;
                m_rest      = TR;
                m_pend[sel] = 0;
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (hit[i]) begin
                m_per[i]  = per;
                m_dias[i] = 0;
                m_pend[i] = 0;
            end else if (tick && m_per[i] != 0) begin
                if (m_dias[i] + 1 == m_per[i]) begin
                    m_dias[i] = 0;
                    m_pend[i] = 1;
                end else begin
                    m_dias[i]++;
                end
            end
        end
    endtask

    function automatic logic [5:0] esperado();
        logic [1:0] pa;
        pa = m_regando ? 2'(m_ativa) : 2'd0;
        return {m_regando && m_ativa == 2, m_regando && m_ativa == 1,
                m_regando && m_ativa == 0, m_regando, pa};
    endfunction

    function automatic logic [5:0] observado();
        return {pump3, pump2, pump1, regando, planta_ativa};
    endfunction

    // Called #1 after a rising edge: drive inputs, advance model, check after next edge.
    task automatic ciclo(input bit v, input int p, input int per);
        cfg_valid   = v;
        cfg_planta  = 2'(p);
        cfg_periodo = 4'(per);
        modelo_passo(v, p, per);
        @(posedge clk);
        #1;
        verifica("saidas", 32'(observado()), 32'(esperado()));
        verifica("uma_bomba", 32'($countones({pump3, pump2, pump1}) <= 1), 32'd1);
    endtask

    task automatic ociosos(input int n);
        for (int k = 0; k < n; k++) ciclo(0, 0, 0);
    endtask

    // Reset asserted between edges; outputs must fall before any clock edge.
    task automatic pulso_reset();
        cfg_valid = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        verifica("rst_assinc", 32'(observado()), 32'd0);
        modelo_reset();
        @(posedge clk);
        #1;
        verifica("rst_mantido", 32'(observado()), 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        modelo_reset();
        repeat (2) @(posedge clk);
        #1;
        verifica("reset", 32'(observado()), 32'd0);
        rst = 1'b0;

        // plant0 every day, then abort in the 2nd watering cycle with period 2
        ciclo(1, 0, 1);
        ociosos(22);
        for (int k = 0; k < 20 && !pump1; k++) ciclo(0, 0, 0);
        verifica("espera_pump1", 32'(pump1), 32'd1);
        ciclo(1, 0, 2);
        verifica("aborto", 32'(pump1), 32'd0);
        ociosos(45);

        // plants 0 and 2 daily, plant1 every third day
        ciclo(1, 0, 1);
        ciclo(1, 2, 1);
        ciclo(1, 1, 3);
        ociosos(70);

        // invalid plant index writes
        for (int k = 0; k < 6; k++) ciclo(1, 3, $urandom_range(0, 15));
        ociosos(20);

        // reset mid-watering, then silence until reconfigured
        for (int k = 0; k < 20 && !regando; k++) ciclo(0, 0, 0);
        verifica("espera_rega", 32'(regando), 32'd1);
        pulso_reset();
        ociosos(40);

        // plant0 disabled right after its request is raised
        ciclo(1, 0, 1);
        for (int k = 0; k < 12 && !pump1; k++) ciclo(0, 0, 0);
        ciclo(1, 0, 0);
        ociosos(30);

        // random configuration traffic
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 599) == 0) begin
                pulso_reset();
            end else if ($urandom_range(0, 15) == 0) begin
                ciclo(1, $urandom_range(0, 3),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3));
            end else begin
                ciclo(0, 0, 0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
